// File: rtl/store_initiator.sv
// store_initiator
// CPU-side initiator for the main store. Accepts FETCH / LOAD / STORE / JUMP
// requests over a valid/ready handshake, drives the store strobes for one
// ACCESS cycle, and returns a one-cycle response pulse in RESP. Owns the
// program counter used for instruction fetch.
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   req_valid / req_ready          request handshake
//   req_op, req_addr, req_wdata    request payload (op: 00 FETCH 01 LOAD 10 STORE 11 JUMP)
//   rsp_valid, rsp_data            registered response pulse and data
//   pc                             current program counter
//   mem_read, mem_write            registered main store strobes
//   mem_address, mem_wdata         registered main store address / write data
//   mem_rdata                      main store read data (combinational from address)
module store_initiator #(
  parameter int          ADDR_W   = 5,
  parameter int          DATA_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] pc,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {OP_FETCH = 2'b00, OP_LOAD = 2'b01,
                            OP_STORE = 2'b10, OP_JUMP = 2'b11} op_t;

  state_t            state_q;
  op_t               op_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              accept;
  op_t               req_op_t;

  assign req_ready = (state_q != ACCESS);
  assign accept    = req_valid & req_ready;
  assign req_op_t  = op_t'(req_op);

  // PC moves only on the edge leaving ACCESS. For JUMP the latched target
  // sits in mem_address_q (strobes stay low, so the address is harmless).
  always_comb begin
    pc_d = pc_q;
    if (state_q == ACCESS) begin
      if (op_q == OP_FETCH)     pc_d = pc_q + ADDR_W'(1);
      else if (op_q == OP_JUMP) pc_d = mem_address_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= OP_FETCH;
      pc_q          <= ADDR_W'(RESET_PC);
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        IDLE, RESP: begin
          // The response pulse lasts exactly the RESP cycle, whether or not
          // a new request is taken in it.
          rsp_valid_q <= 1'b0;
          if (accept) begin
            op_q          <= req_op_t;
            mem_address_q <= (req_op_t == OP_FETCH) ? pc_q : req_addr;
            mem_read_q    <= (req_op_t == OP_FETCH) || (req_op_t == OP_LOAD);
            mem_write_q   <= (req_op_t == OP_STORE);
            if (req_op_t == OP_STORE) mem_wdata_q <= req_wdata;
            state_q       <= ACCESS;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          // Store write commits on this edge; a following LOAD sees it.
          case (op_q)
            OP_FETCH, OP_LOAD: rsp_data_q <= mem_rdata;
            OP_STORE:          rsp_data_q <= mem_wdata_q;
            default:           rsp_data_q <= '0;
          endcase
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign pc          = pc_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_store_initiator.sv
// Bench for store_initiator: a 32x8 main store, a behavioural reference
// (model memory + model PC updated per request), directed steps then random
// requests with random idle gaps.
module tb_store_initiator;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] pc;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  store_initiator #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .pc(pc),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 0) return 8'h3C;
    if (i == 1) return 8'hA5;
    return DW'(i * 29 + 7);
  endfunction

  // Main store: combinational read, synchronous write.
  logic [DW-1:0] smem [32];
  assign mem_rdata = smem[mem_address];
  initial begin
    for (int i = 0; i < 32; i++) smem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_write) smem[mem_address] <= mem_wdata;
    end
  end

  int acc_cnt = 0;
  always @(posedge clk) if (!rst && req_valid && req_ready) acc_cnt <= acc_cnt + 1;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] model_mem [32];
  logic [AW-1:0] model_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request starting in IDLE or RESP (at posedge+1). Returns in the
  // RESP cycle. If hold, the next request (nop/naddr/nwd) is presented during
  // ACCESS with req_valid kept high.
  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input bit hold,
                        input logic [1:0] nop, input logic [AW-1:0] naddr,
                        input logic [DW-1:0] nwd);
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    int a0;
    case (op)
      2'b00: begin exp_a = model_pc; exp_d = model_mem[model_pc]; model_pc = model_pc + 5'd1; end
      2'b01: begin exp_a = addr; exp_d = model_mem[addr]; end
      2'b10: begin exp_a = addr; exp_d = wd; model_mem[addr] = wd; end
      default: begin exp_a = addr; exp_d = '0; model_pc = addr; end
    endcase
    chk("ready_before_accept", 32'(req_ready), 32'(1'b1));
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    a0 = acc_cnt;
    @(posedge clk); #1;
    if (hold) begin
      req_op = nop; req_addr = naddr; req_wdata = nwd;
    end else begin
      req_valid = 1'b0;
    end
    chk("accept_count", 32'(acc_cnt), 32'(a0 + 1));
    chk("ready_in_access", 32'(req_ready), 32'(1'b0));
    chk("rsp_valid_in_access", 32'(rsp_valid), 32'(1'b0));
    chk("mem_read_in_access", 32'(mem_read), 32'(op == 2'b00 || op == 2'b01));
    chk("mem_write_in_access", 32'(mem_write), 32'(op == 2'b10));
    chk("mem_address_in_access", 32'(mem_address), 32'(exp_a));
    if (op == 2'b10) chk("mem_wdata_in_access", 32'(mem_wdata), 32'(wd));
    @(posedge clk); #1;
    chk("no_accept_during_access", 32'(acc_cnt), 32'(a0 + 1));
    chk("rsp_valid_in_resp", 32'(rsp_valid), 32'(1'b1));
    chk("rsp_data", 32'(rsp_data), 32'(exp_d));
    chk("pc_after_access", 32'(pc), 32'(model_pc));
    chk("strobes_clear_in_resp", 32'({mem_read, mem_write}), 32'(2'b00));
    chk("ready_in_resp", 32'(req_ready), 32'(1'b1));
  endtask

  task automatic req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    do_req(op, addr, wd, 1'b0, 2'b00, '0, '0);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      chk("idle_rsp_valid", 32'(rsp_valid), 32'(1'b0));
      chk("idle_strobes", 32'({mem_read, mem_write}), 32'(2'b00));
      chk("idle_ready", 32'(req_ready), 32'(1'b1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) model_mem[i] = init_word(i);
    model_pc = '0;

    // Reset state while rst is held
    #3;
    chk("reset_pc", 32'(pc), 32'(0));
    chk("reset_rsp", 32'({rsp_valid, rsp_data}), 32'(0));
    chk("reset_mem", 32'({mem_read, mem_write, mem_address, mem_wdata}), 32'(0));
    @(posedge clk); #3; rst = 1'b0;
    @(posedge clk); #1;
    idle(5);
    chk("idle_pc", 32'(pc), 32'(0));

    // FETCH, FETCH back-to-back: 3C then A5, pc ends at 2
    req(2'b00, '0, '0);
    req(2'b00, '0, '0);
    chk("fetch_pair_pc", 32'(pc), 32'(2));
    idle(1);

    // STORE 5 <- 7E then LOAD 5
    req(2'b10, 5'd5, 8'h7E);
    req(2'b01, 5'd5, 8'h00);
    idle(1);

    // JUMP 31, FETCH, FETCH: reads 31 then 0, pc wraps to 1
    req(2'b11, 5'd31, 8'hFF);
    req(2'b00, '0, '0);
    req(2'b00, '0, '0);
    chk("wrap_pc", 32'(pc), 32'(1));
    idle(2);

    // req_valid held through ACCESS: LOAD 3, then STORE 3 <- 5A waits for RESP
    do_req(2'b01, 5'd3, 8'h00, 1'b1, 2'b10, 5'd3, 8'h5A);
    req(2'b10, 5'd3, 8'h5A);
    req(2'b01, 5'd3, 8'h00);
    idle(1);

    // Reset during the ACCESS cycle of STORE 9 <- 11
    req_valid = 1'b1; req_op = 2'b10; req_addr = 5'd9; req_wdata = 8'h11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_store_strobe", 32'(mem_write), 32'(1'b1));
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs_zero", 32'({rsp_valid, rsp_data, mem_read, mem_write, mem_address, mem_wdata}), 32'(0));
    chk("abort_pc", 32'(pc), 32'(0));
    #1 rst = 1'b0;
    model_pc = '0;
    idle(3);
    req(2'b01, 5'd9, 8'h00);
    idle(1);

    // Random requests with random gaps (0 = issue in RESP)
    for (int k = 0; k < 60; k++) begin
      logic [1:0]    op;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            gap;
      op  = 2'($urandom_range(0, 3));
      a   = AW'($urandom);
      d   = DW'($urandom);
      gap = $urandom_range(0, 2);
      req(op, a, d);
      if (gap > 0) idle(gap);
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/store_initiator.md
Name: store_initiator

Overview:
- CPU-side initiator for the 32x8 main store.
- Accepts fetch, load, store and jump requests from the control unit over a valid/ready handshake.
- Drives the main store's read, write, address and write-data lines, captures read data, and returns a one-cycle response pulse.
- Owns the program counter used for instruction fetch.

Parameters:
- ADDR_W, 5, main store address width; depth is 2**ADDR_W.
- DATA_W, 8, data word width.
- RESET_PC, 0, program counter value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when high together with req_valid.
- req_op  input  2  00 FETCH, 01 LOAD, 10 STORE, 11 JUMP.
- req_addr  input  ADDR_W  target address for LOAD/STORE/JUMP; ignored for FETCH.
- req_wdata  input  DATA_W  store data; ignored unless STORE.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_data  output  DATA_W  read data for FETCH/LOAD; store data for STORE; zero for JUMP.
- pc  output  ADDR_W  current program counter.
- mem_read  output  1  to main store read.
- mem_write  output  1  to main store write.
- mem_address  output  ADDR_W  to main store address.
- mem_wdata  output  DATA_W  to main store data_i.
- mem_rdata  input  DATA_W  from main store data_o; combinational from the addressed word.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state=IDLE, pc=RESET_PC, rsp_valid=0, rsp_data=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0. Applies immediately on rst assertion, including mid-operation. An in-flight request is dropped with no response. A store aborted before its ACCESS edge is not written.
- States: IDLE, ACCESS, RESP. All mem_* and rsp_* outputs are registered.
- req_ready = 1 in IDLE and RESP, 0 in ACCESS.
- Accept edge (req_valid & req_ready):
  - Latch op.
  - mem_address <= pc for FETCH, req_addr otherwise.
  - mem_read <= 1 for FETCH/LOAD.
  - mem_write <= 1 for STORE.
  - mem_wdata <= req_wdata for STORE, else unchanged.
  - Go to ACCESS.
- JUMP: no strobes driven.
- ACCESS, one cycle:
  - Strobes are high for exactly this cycle.
  - On the exiting edge: rsp_data <= mem_rdata for FETCH/LOAD, mem_wdata for STORE, 0 for JUMP.
  - Clear mem_read/mem_write, set rsp_valid, go to RESP.
  - FETCH: pc <= pc+1 mod 2**ADDR_W (31 wraps to 0).
  - JUMP: pc <= latched address.
- RESP, one cycle:
  - rsp_valid=1.
  - If a new request is accepted this cycle, go to ACCESS as above; else go to IDLE and clear rsp_valid.
  - rsp_data holds its value until the next ACCESS exit.
- Latency: response is asserted 2 cycles after the accept edge. Back-to-back throughput is one request per 2 cycles.
- mem_address holds its last value in IDLE/RESP. mem_read and mem_write are never both high.
- STORE then LOAD to the same address: the write commits on the STORE ACCESS edge, so the LOAD returns the new data with no hazard logic.
- req_valid with req_ready=0: request ignored. The requester holds it stable until accepted.
- No other op encodings exist; all four are defined.

Test Plan:
- Reset, then idle 5 cycles -> pc=0, mem_read/mem_write/rsp_valid=0, req_ready=1 throughout.
- Memory preloaded word 0=8'h3C, word 1=8'hA5; FETCH, FETCH back-to-back (second issued in the RESP of the first) -> rsp_data 8'h3C then 8'hA5, each rsp_valid exactly 2 cycles after its accept, mem_address 0 then 1, pc ends at 2.
- STORE addr 5 data 8'h7E, then LOAD addr 5 -> mem_write high for exactly one cycle with address 5; STORE rsp_data=8'h7E; LOAD rsp_data=8'h7E.
- JUMP 31, FETCH, FETCH -> no strobes during JUMP; fetches read addresses 31 then 0; pc wraps to 1.
- req_valid held during ACCESS -> not accepted until the RESP cycle; no duplicate accept, no lost request.
- rst pulsed during the ACCESS cycle of STORE addr 9 data 8'h11 -> all outputs zero immediately, no rsp_valid, pc=0, and word 9 is unchanged on a later LOAD.
